// File: rtl/key_seq_unlock.sv
// key_seq_unlock: serial key-sequence decoder with failure counting, timed lockout and relock.
// Define KEY_SEQ_STICKY_EN to make ACTIVE terminal (relock ignored; only reset leaves ACTIVE).
module key_seq_unlock #(
    parameter int                 KEY_LEN     = 4,
    parameter logic [KEY_LEN-1:0] KEY_PATTERN = 4'b1010,
    parameter int                 MODE_W      = 1,
    parameter int                 MAX_FAILS   = 3,
    parameter int                 LOCKOUT_CYC = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               input_key,
    input  logic                               valid_cmd,
    input  logic                               relock,
    output logic                               active,
    output logic [MODE_W-1:0]                  mode,
    output logic                               locked_out,
    output logic [$clog2(MAX_FAILS+1)-1:0]     fails
);

    localparam int IDX_W  = $clog2(KEY_LEN + 1);
    localparam int MCNT_W = $clog2(MODE_W + 1);
    localparam int FAIL_W = $clog2(MAX_FAILS + 1);
    localparam int LOCK_W = $clog2(LOCKOUT_CYC + 1);

`ifdef KEY_SEQ_STICKY_EN
    localparam logic RELOCK_EN = 1'b0;
`else
    localparam logic RELOCK_EN = 1'b1;
`endif

    typedef enum logic [2:0] {
        IDLE,
        MATCH,
        MODE,
        ACTIVE,
        LOCKOUT
    } state_t;

    state_t              state_q;
    logic [IDX_W-1:0]    idx_q;
    logic [MCNT_W-1:0]   modeCnt_q;
    logic [MODE_W-1:0]   modeShift_q;
    logic [MODE_W-1:0]   mode_q;
    logic                active_q;
    logic                lockedOut_q;
    logic [FAIL_W-1:0]   fails_q;
    logic [LOCK_W-1:0]   lockCnt_q;

    logic                expBit;
    logic [MODE_W-1:0]   shiftNext_d;
    logic [FAIL_W-1:0]   failsNext_d;
    logic                lockHit;
    logic                relockReq;

    always_comb begin
        expBit = 1'b0;
        for (int i = 0; i < KEY_LEN; i++) begin
            if (idx_q == IDX_W'(i)) begin
                expBit = KEY_PATTERN[KEY_LEN-1-i];
            end
        end
        shiftNext_d = (modeShift_q << 1) | MODE_W'(input_key);
        failsNext_d = (fails_q < FAIL_W'(MAX_FAILS)) ? fails_q + FAIL_W'(1) : fails_q;
        lockHit     = (failsNext_d == FAIL_W'(MAX_FAILS));
        relockReq   = relock & RELOCK_EN;
    end

    // A wrong key bit after the first one counts as a failure; a gap or relock just abandons the attempt.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            modeCnt_q   <= '0;
            modeShift_q <= '0;
            mode_q      <= '0;
            active_q    <= 1'b0;
            lockedOut_q <= 1'b0;
            fails_q     <= '0;
            lockCnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid_cmd && (input_key == KEY_PATTERN[KEY_LEN-1])) begin
                        if (KEY_LEN == 1) begin
                            state_q     <= MODE;
                            modeCnt_q   <= '0;
                            modeShift_q <= '0;
                        end else begin
                            state_q <= MATCH;
                            idx_q   <= IDX_W'(1);
                        end
                    end
                end
                MATCH: begin
                    if (relockReq || !valid_cmd) begin
                        state_q <= IDLE;
                        idx_q   <= '0;
                    end else if (input_key == expBit) begin
                        if (idx_q == IDX_W'(KEY_LEN - 1)) begin
                            state_q     <= MODE;
                            idx_q       <= '0;
                            modeCnt_q   <= '0;
                            modeShift_q <= '0;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end else begin
                        idx_q   <= '0;
                        fails_q <= failsNext_d;
                        if (lockHit) begin
                            state_q     <= LOCKOUT;
                            lockedOut_q <= 1'b1;
                            lockCnt_q   <= LOCK_W'(LOCKOUT_CYC);
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                MODE: begin
                    if (relockReq || !valid_cmd) begin
                        state_q     <= IDLE;
                        modeCnt_q   <= '0;
                        modeShift_q <= '0;
                    end else if (modeCnt_q == MCNT_W'(MODE_W - 1)) begin
                        state_q     <= ACTIVE;
                        active_q    <= 1'b1;
                        mode_q      <= shiftNext_d;
                        fails_q     <= '0;
                        modeCnt_q   <= '0;
                        modeShift_q <= '0;
                    end else begin
                        modeShift_q <= shiftNext_d;
                        modeCnt_q   <= modeCnt_q + MCNT_W'(1);
                    end
                end
                ACTIVE: begin
                    if (relockReq) begin
                        state_q  <= IDLE;
                        active_q <= 1'b0;
                        mode_q   <= '0;
                    end
                end
                LOCKOUT: begin
                    // Leaving on the count of 1 keeps locked_out high for exactly LOCKOUT_CYC cycles.
                    if (lockCnt_q <= LOCK_W'(1)) begin
                        state_q     <= IDLE;
                        lockedOut_q <= 1'b0;
                        lockCnt_q   <= '0;
                        fails_q     <= '0;
                    end else begin
                        lockCnt_q <= lockCnt_q - LOCK_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign active     = active_q;
    assign mode       = active_q ? mode_q : '0;
    assign locked_out = lockedOut_q;
    assign fails      = fails_q;

endmodule
